processor_mc: RTL and testbench

- Parametrised multicycle successor to the single-issue teaching processor.
- Host loads the instruction memory through addr/wEn/wDat while working=0, then raises working to run the program.
- Adds configurable data width, register count and imem depth, plus flags, jumps, HALT, pause/resume and a retired-instruction counter.
- Registers are read back through rID/rdata.

---
 rtl/processor_mc.sv | 147 ++++++++++++++
 tb/tb_processor_mc.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_mc.sv
// processor_mc: parametrised two-cycle (FETCH/EXEC) processor with host-loaded imem.
// Define MULTIPLY_EN to make opcode 0x25 a flag-setting MUL; otherwise 0x25 is a NOP.
module processor_mc #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NREGS      = 8,
    parameter int unsigned IMEM_DEPTH = 512,
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wEn,
    input  logic [31:0]       wDat,
    input  logic              working,
    input  logic [3:0]        rID,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] pc,
    output logic              zf,
    output logic              nf,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              zf_q, zf_d, nf_q, nf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] regs_d [16];
    logic [31:0]       imem_q [IMEM_DEPTH];

    logic [7:0]        opc;
    logic [3:0]        ra, rb;
    logic [15:0]       imm;
    logic [DATA_W-1:0] va, vb, res;
    logic              alu_en;
    logic [ADDR_W-1:0] pc_inc, tgt;

    assign opc = ir_q[31:24];
    assign ra  = ir_q[23:20];
    assign rb  = ir_q[19:16];
    assign imm = ir_q[15:0];

    // Indices at or above NREGS read as zero; those entries are never written.
    assign va     = (32'(ra) < NREGS) ? regs_q[ra] : '0;
    assign vb     = (32'(rb) < NREGS) ? regs_q[rb] : '0;
    assign rdata  = (32'(rID) < NREGS) ? regs_q[rID] : '0;
    assign pc_inc = (pc_q == ADDR_W'(IMEM_DEPTH - 1)) ? '0 : pc_q + ADDR_W'(1);
    assign tgt    = ADDR_W'({16'b0, imm} % IMEM_DEPTH);

    assign pc          = pc_q;
    assign zf          = zf_q;
    assign nf          = nf_q;
    assign halted      = (state_q == S_HALT);
    assign instr_count = cnt_q;

    always_ff @(posedge clock) begin
        if (wEn && !working && (32'(addr) < IMEM_DEPTH))
            imem_q[addr] <= wDat;
    end

    always_comb begin
        alu_en = 1'b0;
        res    = '0;
        case (opc)
            8'h20: begin alu_en = 1'b1; res = va + vb; end
            8'h21: begin alu_en = 1'b1; res = va - vb; end
            8'h22: begin alu_en = 1'b1; res = va & vb; end
            8'h23: begin alu_en = 1'b1; res = va | vb; end
            8'h24: begin alu_en = 1'b1; res = va ^ vb; end
`ifdef MULTIPLY_EN
            8'h25: begin alu_en = 1'b1; res = va * vb; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        zf_d    = zf_q;
        nf_d    = nf_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        case (state_q)
            S_FETCH: begin
                if (working) begin
                    ir_d    = imem_q[pc_q];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (working) begin
                    if (opc == 8'h00) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = pc_inc;
                        if (cnt_q != '1)
                            cnt_d = cnt_q + CNT_W'(1);
                        case (opc)
                            8'h10: if (32'(rb) < NREGS) regs_d[rb] = DATA_W'(imm);
                            8'h70: pc_d = tgt;
                            8'h73: if (zf_q) pc_d = tgt;
                            default: ;
                        endcase
                        if (alu_en) begin
                            if (32'(ra) < NREGS)
                                regs_d[ra] = res;
                            zf_d = (res == '0);
                            nf_d = res[DATA_W-1];
                        end
                    end
                end
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            pc_q    <= '0;
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < 16; i++)
                regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            zf_q    <= zf_d;
            nf_q    <= nf_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
        end
    end

endmodule

// File: tb/tb_processor_mc.sv
// Bench for processor_mc: directed programs plus random programs checked against an ISA-level model.
module tb_processor_mc;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    always #5 clock = ~clock;

    logic [8:0]  addr = '0;
    logic        wEn = 1'b0;
    logic [31:0] wDat = '0;
    logic        working = 1'b0;
    logic [3:0]  rID = '0;
    logic [31:0] rdata;
    logic [8:0]  pc;
    logic        zf, nf, halted;
    logic [15:0] instr_count;

    logic [2:0]  s_addr = '0;
    logic        s_wEn = 1'b0;
    logic [31:0] s_wDat = '0;
    logic        s_working = 1'b0;
    logic [3:0]  s_rID = '0;
    logic [7:0]  s_rdata;
    logic [2:0]  s_pc;
    logic        s_zf, s_nf, s_halted;
    logic [3:0]  s_cnt;

    processor_mc dut (
        .clock(clock), .reset(reset), .addr(addr), .wEn(wEn), .wDat(wDat),
        .working(working), .rID(rID), .rdata(rdata), .pc(pc), .zf(zf), .nf(nf),
        .halted(halted), .instr_count(instr_count)
    );

    processor_mc #(.DATA_W(8), .NREGS(4), .IMEM_DEPTH(8), .ADDR_W(3), .CNT_W(4)) u_small (
        .clock(clock), .reset(reset), .addr(s_addr), .wEn(s_wEn), .wDat(s_wDat),
        .working(s_working), .rID(s_rID), .rdata(s_rdata), .pc(s_pc), .zf(s_zf), .nf(s_nf),
        .halted(s_halted), .instr_count(s_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] prog [512];
    int          prog_len;
    int unsigned m_regs [16];
    bit          m_zf, m_nf;
    int unsigned m_pc, m_cnt;
    int unsigned expA [8] = '{32'h39, 32'h56, 32'hFFFFFFFF, 32'h1F, 32'h20, 32'h21, 0, 0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        tick();
        working = 1'b0;
        wEn     = 1'b0;
        reset   = 1'b1;
        #1;
        reset   = 1'b0;
        #1;
    endtask

    task automatic load_prog();
        working = 1'b0;
        for (int i = 0; i < prog_len; i++) begin
            addr = 9'(i);
            wDat = prog[i];
            wEn  = 1'b1;
            tick();
        end
        wEn = 1'b0;
    endtask

    task automatic run_until_halt(output int cyc);
        cyc = 0;
        while (halted !== 1'b1 && cyc < 1000) begin
            tick();
            cyc++;
        end
    endtask

    // Instruction-by-instruction interpreter over prog[]; stops at the first HALT.
    function automatic void model_run();
        int unsigned pcm, nxt, w, op, ra, rb, imm, va, vb, res;
        bit alu, done;
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_zf = 0; m_nf = 0; m_cnt = 0; pcm = 0; done = 0;
        for (int step = 0; step < 2000 && !done; step++) begin
            w   = prog[pcm];
            op  = w >> 24;
            ra  = (w >> 20) & 15;
            rb  = (w >> 16) & 15;
            imm = w & 32'hFFFF;
            va  = (ra < 8) ? m_regs[ra] : 0;
            vb  = (rb < 8) ? m_regs[rb] : 0;
            if (op == 0) begin
                done = 1;
            end else begin
                m_cnt++;
                nxt = (pcm + 1) % 512;
                alu = 0;
                res = 0;
                case (op)
                    'h10: if (rb < 8) m_regs[rb] = imm;
                    'h20: begin res = va + vb; alu = 1; end
                    'h21: begin res = va - vb; alu = 1; end
                    'h22: begin res = va & vb; alu = 1; end
                    'h23: begin res = va | vb; alu = 1; end
                    'h24: begin res = va ^ vb; alu = 1; end
                    'h25: begin
`ifdef MULTIPLY_EN
                        res = va * vb; alu = 1;
`endif
                    end
                    'h70: nxt = imm % 512;
                    'h73: if (m_zf) nxt = imm % 512;
                    default: ;
                endcase
                if (alu) begin
                    if (ra < 8) m_regs[ra] = res;
                    m_zf = (res == 0);
                    m_nf = res[31];
                end
                pcm = nxt;
            end
        end
        m_pc = pcm;
    endfunction

    task automatic check_model(input string tag);
        for (int r = 0; r < 16; r++) begin
            rID = 4'(r);
            #1;
            check($sformatf("%s_r%0d", tag, r), rdata, (r < 8) ? m_regs[r] : 0);
        end
        check({tag, "_zf"}, zf, m_zf);
        check({tag, "_nf"}, nf, m_nf);
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_cnt"}, instr_count, m_cnt);
        check({tag, "_halted"}, halted, 1'b1);
    endtask

    task automatic check_progA(input string tag);
        for (int r = 0; r < 8; r++) begin
            rID = 4'(r);
            #1;
            check($sformatf("%s_r%0d", tag, r), rdata, expA[r]);
        end
        rID = 4'd12;
        #1;
        check({tag, "_r12"}, rdata, 0);
        check({tag, "_cnt"}, instr_count, 10);
        check({tag, "_pc"}, pc, 10);
        check({tag, "_zf"}, zf, 1'b0);
        check({tag, "_nf"}, nf, 1'b0);
    endtask

    initial begin
        int cyc;
        int unsigned L, kind, op, ra, rb, imm, tg;

        // Power-on reset
        reset = 1'b1;
        #2;
        check("rst_pc", pc, 0);
        check("rst_halted", halted, 1'b0);
        check("rst_cnt", instr_count, 0);
        check("rst_zf", zf, 1'b0);
        check("rst_nf", nf, 1'b0);
        check("rst_rdata", rdata, 0);
        tick();
        reset = 1'b0;

        // Program A, with a write attempt held while running
        for (int i = 0; i < 6; i++) prog[i] = 32'h1000001C + (i << 16) + i;
        prog[6] = 32'h20010000; prog[7] = 32'h21230000; prog[8] = 32'h22450000;
        prog[9] = 32'h20100000; prog[10] = 32'h00000000;
        prog_len = 11;
        load_prog();
        working = 1'b1;
        wEn = 1'b1; addr = 9'd10; wDat = 32'h10000005;
        run_until_halt(cyc);
        wEn = 1'b0;
        check("A_cycles", cyc, 22);
        check_progA("A");

        // Pause after cycle 9 for 5 cycles
        pulse_reset();
        working = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        working = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("P_pc", pc, 4);
        check("P_cnt", instr_count, 4);
        check("P_zf", zf, 1'b0);
        check("P_halted", halted, 1'b0);
        rID = 4'd3; #1; check("P_r3", rdata, 32'h1F);
        rID = 4'd4; #1; check("P_r4", rdata, 0);
        working = 1'b1;
        run_until_halt(cyc);
        check("P_cycles", cyc + 14, 27);
        check_progA("P");

        // Reset mid-instruction at cycle 7, then rerun without reloading
        pulse_reset();
        working = 1'b1;
        rID = 4'd0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        working = 1'b0;
        #1;
        check("R_r0_during", rdata, 0);
        check("R_pc_during", pc, 0);
        check("R_halted_during", halted, 1'b0);
        #1;
        reset = 1'b0;
        for (int r = 0; r < 16; r++) begin
            rID = 4'(r);
            #1;
            check($sformatf("R_zero_r%0d", r), rdata, 0);
        end
        check("R_cnt", instr_count, 0);
        working = 1'b1;
        run_until_halt(cyc);
        check("R_cycles", cyc, 22);
        check_progA("R");

        // Countdown loop with JE/JMP
        pulse_reset();
        prog[0] = 32'h10010003; prog[1] = 32'h10020001; prog[2] = 32'h21120000;
        prog[3] = 32'h73000005; prog[4] = 32'h70000002; prog[5] = 32'h00000000;
        prog_len = 6;
        load_prog();
        working = 1'b1;
        run_until_halt(cyc);
        check("L_cycles", cyc, 22);
        rID = 4'd1; #1; check("L_r1", rdata, 0);
        rID = 4'd2; #1; check("L_r2", rdata, 1);
        check("L_zf", zf, 1'b1);
        check("L_pc", pc, 5);
        check("L_cnt", instr_count, 10);
        model_run();
        check_model("Lm");

        // Multiply opcode
        pulse_reset();
        prog[0] = 32'h10000006; prog[1] = 32'h10010007; prog[2] = 32'h25010000; prog[3] = 32'h0;
        prog_len = 4;
        load_prog();
        working = 1'b1;
        run_until_halt(cyc);
        check("M_cycles", cyc, 8);
        rID = 4'd0; #1;
`ifdef MULTIPLY_EN
        check("M_r0", rdata, 32'h2A);
`else
        check("M_r0", rdata, 32'h6);
`endif
        check("M_cnt", instr_count, 3);

        // Random forward-branching programs against the model
        for (int t = 0; t < 8; t++) begin
            L = $urandom_range(4, 23);
            for (int unsigned i = 0; i < L; i++) begin
                kind = $urandom_range(0, 11);
                ra   = $urandom_range(0, 15);
                rb   = $urandom_range(0, 15);
                imm  = $urandom_range(0, 65535);
                if (kind <= 2) op = 'h10;
                else if (kind <= 8) op = 'h20 + kind - 3;
                else if (kind == 11) op = $urandom_range(1, 15);
                else begin
                    op  = (kind == 9) ? 'h70 : 'h73;
                    tg  = $urandom_range(i + 1, L);
                    imm = tg + 512 * $urandom_range(0, 127);
                end
                prog[i] = (op << 24) | (ra << 20) | (rb << 16) | imm;
            end
            prog[L] = 32'h0;
            prog_len = int'(L) + 1;
            pulse_reset();
            load_prog();
            model_run();
            working = 1'b1;
            run_until_halt(cyc);
            check($sformatf("rnd%0d_cycles", t), cyc, 2 * (m_cnt + 1));
            check_model($sformatf("rnd%0d", t));
        end

        // Small instance: pc wrap and counter saturation
        for (int i = 0; i < 8; i++) begin
            s_addr = 3'(i);
            s_wDat = 32'h01000000;
            s_wEn  = 1'b1;
            tick();
        end
        s_wEn = 1'b0;
        s_working = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        check("S_pc7", s_pc, 7);
        check("S_cnt7", s_cnt, 7);
        for (int i = 0; i < 2; i++) tick();
        check("S_pc_wrap", s_pc, 0);
        check("S_cnt8", s_cnt, 8);
        for (int i = 0; i < 24; i++) tick();
        check("S_cnt_sat", s_cnt, 15);
        check("S_pc4", s_pc, 4);
        check("S_halted", s_halted, 1'b0);
        s_rID = 4'd12; #1;
        check("S_r12", s_rdata, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
